fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage at the front of the pipeline: owns the fetch PC, issues in-order reads to
//  instruction memory, buffers returned 16-bit instructions and presents them to decode with their PC.
//  Consumes the execute stage's redirect (flush + target PC) and discards any stale in-flight fetches.
// PARAMETERS
//  RESET_PC   16'h0000  fetch PC loaded on reset
//  BUF_DEPTH  2         instruction buffer entries; also the max outstanding-plus-buffered credit (2..4)
// PORTS
//  clk           in   1   pipeline clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  Redirect      in   1   flush from execute: discard all fetched/in-flight instrs, refetch at RedirectPC
//  RedirectPC    in   16  new fetch PC (execute's PCOut), valid when Redirect=1
//  Stall         in   1   decode cannot accept this cycle (hazard/stall)
//  IMemReq       out  1   fetch request valid
//  IMemAddr      out  16  fetch word address (= FetchPC)
//  IMemReady     in   1   imem accepts request this cycle (transfer = IMemReq & IMemReady)
//  IMemRspValid  in   1   read data returned; responses are in request order, latency >= 1 cycle
//  IMemRspData   in   16  returned instruction
//  InstrValid    out  1   InstrOut/InstrPC/PCPlus1 hold a valid instruction for decode
//  InstrOut      out  16  instruction at buffer head
//  InstrPC       out  16  address of InstrOut
//  PCPlus1       out  16  InstrPC + 1 (mod 2^16); fall-through PC carried to execute's PCIn
// BEHAVIOUR
//  Reset: FSM=BOOT, FetchPC=RESET_PC, buffer empty, Outstanding=0; IMemReq=0, InstrValid=0,
//   InstrOut=0, InstrPC=0, PCPlus1=0. Reset mid-operation abandons everything; later responses ignored
//   only if they arrive during reset (imem is reset with the core).
//  FSM states:
//   BOOT  : one cycle, no request -> FETCH.
//   FETCH : IMemReq=1 iff Outstanding + BufCount < BUF_DEPTH and Redirect=0. On transfer: Outstanding+1,
//           FetchPC+1 (16-bit wrap, FFFF->0000). Redirect with Outstanding (after this cycle's response)
//           >0 -> DRAIN; with 0 -> stay FETCH, request from RedirectPC next cycle.
//   DRAIN : IMemReq=0; every response is dropped, Outstanding-1; when last outstanding response arrives
//           -> FETCH next cycle. Redirect in DRAIN only reloads FetchPC.
//  Response in FETCH (no Redirect): written to buffer tail with its PC (tracked PC of oldest in-flight),
//   Outstanding-1. Credit rule guarantees the buffer never overflows; overflow attempt is an assertion.
//  Decode side: InstrValid = (BufCount>0) & ~Redirect. Head pops when InstrValid & ~Stall. Push and pop
//   same cycle allowed (count unchanged). Outputs driven from buffer registers, 0 latency from entry.
//  Redirect (any state): next-cycle FetchPC=RedirectPC, buffer emptied, response arriving same cycle
//   dropped; a request transfer in the Redirect cycle never occurs (IMemReq gated). Redirect beats Stall.
//  Latency: redirect to first request = 1 cycle if no outstanding; request to InstrValid = imem latency.
//  Throughput: 1 instr/cycle with 1-cycle imem and BUF_DEPTH>=2.
//  Outstanding width = clog2(BUF_DEPTH)+1; never exceeds BUF_DEPTH (assert).
// TESTING
//  1. Reset, 1-cycle imem, Stall=0 -> IMemAddr 0,1,2,3 on consecutive cycles; InstrPC 0,1,2 with
//     PCPlus1 1,2,3, one instr/cycle after 2-cycle startup.
//  2. Stall=1 for 4 cycles with buffer full -> IMemReq=0, InstrOut/InstrPC held; release -> resumes in order.
//  3. 3-cycle imem, 2 outstanding, Redirect to 16'h0040 -> DRAIN, both responses dropped, InstrValid=0
//     until response from 0x0040; next IMemAddr=0x0040.
//  4. Redirect same cycle as IMemRspValid and Stall=1 -> response dropped, buffer empty next cycle,
//     fetch resumes at RedirectPC.
//  5. RESET_PC=16'hFFFE -> fetch addresses FFFE,FFFF,0000; PCPlus1 for FFFF = 0000.
//  6. Assert rst_n low mid-DRAIN -> outputs return to reset values asynchronously; BOOT then fetch RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem reads under a credit limit,
// buffers returned instructions for decode and squashes stale fetches when execute redirects.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Redirect,
    input  logic [15:0] RedirectPC,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRspValid,
    input  logic [15:0] IMemRspData,
    output logic        InstrValid,
    output logic [15:0] InstrOut,
    output logic [15:0] InstrPC,
    output logic [15:0] PCPlus1
);
    localparam int OW = $clog2(BUF_DEPTH) + 1;
    localparam int IW = $clog2(BUF_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);
    localparam logic [OW-1:0] DEPTH_W  = OW'(BUF_DEPTH);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] buf_count_q, buf_count_d;
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [15:0]   buf_instr_q [BUF_DEPTH];
    logic [15:0]   buf_instr_d [BUF_DEPTH];
    logic [15:0]   buf_pc_q    [BUF_DEPTH];
    logic [15:0]   buf_pc_d    [BUF_DEPTH];

    logic          has_entry;
    logic          pop;
    logic          xfer;
    logic          rsp_seen;
    logic          push;
    logic [OW:0]   credit_used;
    logic [15:0]   rsp_pc;
    logic [15:0]   head_pc;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign has_entry  = (buf_count_q != '0);
    assign InstrValid = has_entry & ~Redirect;
    assign pop        = InstrValid & ~Stall;

    // A slot freed by this cycle's pop counts as available credit, which sustains 1 instr/cycle.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, buf_count_q} - {{OW{1'b0}}, pop};
    assign IMemReq     = (state_q == FETCH) & ~Redirect & (credit_used < {1'b0, DEPTH_W});
    assign IMemAddr    = fetch_pc_q;
    assign xfer        = IMemReq & IMemReady;

    // In FETCH every in-flight request is consecutive and ends at fetch_pc_q - 1.
    assign rsp_seen = IMemRspValid & (outstanding_q != '0);
    assign push     = rsp_seen & (state_q == FETCH) & ~Redirect;
    assign rsp_pc   = fetch_pc_q - 16'(outstanding_q);

    assign head_pc  = buf_pc_q[head_q];
    assign InstrOut = has_entry ? buf_instr_q[head_q] : '0;
    assign InstrPC  = has_entry ? head_pc : '0;
    assign PCPlus1  = has_entry ? head_pc + 16'd1 : '0;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + OW'(xfer) - OW'(rsp_seen);
        buf_count_d   = buf_count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;

        if (xfer) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
        end

        if (Redirect) begin
            fetch_pc_d  = RedirectPC;
            buf_count_d = '0;
            head_d      = '0;
            tail_d      = '0;
        end else begin
            if (push) begin
                buf_instr_d[tail_q] = IMemRspData;
                buf_pc_d[tail_q]    = rsp_pc;
                tail_d              = next_idx(tail_q);
            end
            if (pop) begin
                head_d = next_idx(head_q);
            end
            buf_count_d = buf_count_q + OW'(push) - OW'(pop);
        end

        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (Redirect && outstanding_d != '0) state_d = DRAIN;
            DRAIN:   if (outstanding_d == '0) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            buf_count_q   <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            buf_count_q   <= buf_count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

    // The credit limit must make both of these impossible.
    buffer_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && buf_count_q == DEPTH_W));
    outstanding_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= DEPTH_W);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural imem answers requests in order, and a program-flow
// model (consecutive PCs since the last reset or redirect) predicts every request and decoded instruction.
module tb_fetch_unit;
    localparam logic [15:0] RST_PC = 16'hFFFE;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        Stall;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRspValid;
    logic [15:0] IMemRspData;
    logic        InstrValid;
    logic [15:0] InstrOut;
    logic [15:0] InstrPC;
    logic [15:0] PCPlus1;

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
        .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
        .InstrValid(InstrValid), .InstrOut(InstrOut), .InstrPC(InstrPC), .PCPlus1(PCPlus1)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    req_t        pend_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] next_push_pc;
    logic [15:0] exp_req_addr;
    int          stale = 0;
    bit          expect_req = 0;
    int          since = 0;
    int          idle = 0;
    int          pops = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: an odd multiplier keeps every address's word distinct.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        w = a * 16'd40503;
        return w ^ 16'h5A3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_push_pc);
            next_push_pc = next_push_pc + 16'd1;
        end
    endtask

    task automatic applyStimulus(input bit redir, input logic [15:0] rpc, input bit stall);
        @(negedge clk);
        Redirect   = redir;
        RedirectPC = rpc;
        Stall      = stall;
        if (redir) begin
            exp_q.delete();
            next_push_pc = rpc;
        end
        top_up();
    endtask

    task automatic doReset(input int hold);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        Redirect = 1'b0;
        Stall    = 1'b0;
        #1;
        checkOutput("rst_req", IMemReq, 0);
        checkOutput("rst_valid", InstrValid, 0);
        checkOutput("rst_instr", InstrOut, 0);
        checkOutput("rst_pc", InstrPC, 0);
        checkOutput("rst_pcplus1", PCPlus1, 0);
        checkOutput("rst_addr", IMemAddr, RST_PC);
        exp_q.delete();
        pend_q.delete();
        stale        = 0;
        expect_req   = 0;
        since        = 0;
        idle         = 0;
        exp_req_addr = RST_PC;
        next_push_pc = RST_PC;
        repeat (hold) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        top_up();
    endtask

    // Behavioural instruction memory: random ready, in-order responses after lat_min..lat_max cycles.
    initial begin : imem
        IMemReady    = 1'b0;
        IMemRspValid = 1'b0;
        IMemRspData  = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                pend_q.delete();
                IMemReady    = 1'b0;
                IMemRspValid = 1'b0;
                continue;
            end
            IMemReady = (int'($urandom_range(99)) < ready_pct);
            if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
                IMemRspValid = 1'b1;
                IMemRspData  = mem_word(pend_q[0].addr);
                pend_q.delete(0);
            end else begin
                IMemRspValid = 1'b0;
                IMemRspData  = 16'($urandom);
            end
            #2;
            if (rst_n && IMemReq && IMemReady)
                pend_q.push_back('{IMemAddr, cycle + int'($urandom_range(lat_max, lat_min))});
        end
    end

    // Monitor: compares request addresses and decode output against the program-flow model.
    initial begin : monitor
        logic [15:0] e;
        logic [15:0] e1;
        bit          prev_redir;
        prev_redir = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_redir = 1'b0;
                continue;
            end
            if (since == 0) checkOutput("boot_no_req", IMemReq, 0);
            if (Redirect) begin
                checkOutput("redirect_valid", InstrValid, 0);
                checkOutput("redirect_req", IMemReq, 0);
            end
            if (prev_redir) checkOutput("post_redirect_empty", InstrValid, 0);
            if (expect_req && !Redirect) checkOutput("req_after_flush", IMemReq, 1);
            if (stale > 0) checkOutput("drain_no_req", IMemReq, 0);
            if (IMemReq && IMemReady) begin
                checkOutput("fetch_addr", IMemAddr, exp_req_addr);
                checkOutput("credit", pend_q.size() < DEPTH, 1);
                exp_req_addr = exp_req_addr + 16'd1;
            end
            if (InstrValid && exp_q.size() > 0) begin
                e  = exp_q[0];
                e1 = e + 16'd1;
                checkOutput("instr_pc", InstrPC, e);
                checkOutput("instr_out", InstrOut, mem_word(e));
                checkOutput("pc_plus1", PCPlus1, e1);
                if (!Stall) begin
                    exp_q.delete(0);
                    pops++;
                end
            end
            if (Redirect || (InstrValid && !Stall)) idle = 0;
            else idle++;
            checkOutput("progress", idle > 64, 0);
            if (idle > 64) idle = 0;

            if (Redirect) begin
                stale        = pend_q.size();
                exp_req_addr = RedirectPC;
                expect_req   = (stale == 0);
            end else begin
                expect_req = (since == 0);
                if (stale > 0 && IMemRspValid) begin
                    stale--;
                    if (stale == 0) expect_req = 1'b1;
                end
            end
            prev_redir = Redirect;
            since++;
        end
    end

    initial begin : stimulus
        bit seen;
        rst_n      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = '0;
        Stall      = 1'b0;
        doReset(2);

        // Streaming from reset with 1-cycle imem; addresses wrap FFFE, FFFF, 0000.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
            #3;
            checkOutput("stream_req", IMemReq, 1);
            if (k >= 3) checkOutput("stream_valid", InstrValid, 1);
        end

        // Decode stalls with a full buffer, then releases.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            #3;
            checkOutput("stall_no_req", IMemReq, 0);
        end
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0, 1'b0);

        // 3-cycle imem with two in flight, then redirect to 0x0040.
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h0040, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
            #3;
            seen = IMemReq;
        end
        checkOutput("redirect_refetch", seen, 1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 16'h0, 1'b0);

        // Reset arriving while the unit is draining.
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h0100, 1'b0);
        doReset(2);
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h0, 1'b0);

        // Redirect coinciding with a response and a decode stall.
        applyStimulus(1'b1, 16'h1234, 1'b1);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 16'h0, 1'b0);

        // Randomized traffic, including occasional mid-run resets.
        lat_min   = 1;
        lat_max   = 4;
        ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            bit          redir;
            bit          stl;
            logic [15:0] rpc;
            redir = (int'($urandom_range(99)) < 4);
            stl   = (int'($urandom_range(99)) < 25);
            rpc   = ($urandom_range(3) == 0) ? 16'hFFFD + 16'($urandom_range(2)) : 16'($urandom);
            if (i == 1000 || i == 2000) doReset(1);
            else applyStimulus(redir, rpc, stl);
        end
        for (int k = 0; k < 30; k++) applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("min_throughput", pops >= 300, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
